wave_sequencer_ctrl: RTL and testbench

Control block for the sawtooth/triangle/square waveform generators. It accepts configuration requests (mode, maximum, minimum, sample divider) over a valid/ready handshake and validates them. It computes the per-sample step with a multi-cycle divider, then applies the new set glitch-free at the next period boundary. It also produces the sample strobe and sample index that sequence the generator datapath feeding the DAC.

---
 rtl/wave_sequencer_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_wave_sequencer_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_sequencer_ctrl.sv
// -----------------------------------------------------------------------------
// wave_sequencer_ctrl
//
// Control block for the sawtooth / triangle / square waveform generators.
// It accepts configuration requests and checks them. It then computes the
// per-sample amplitude step with a multi-cycle restoring divider, and swaps the
// new configuration in at a waveform period boundary so that a period is never
// generated with mixed settings. It also produces the sample strobe and sample
// index that sequence the generator datapath.
//
// Ports
//   clock, reset_n         system clock, asynchronous active-low reset
//   cfg_valid / cfg_ready  configuration request handshake
//   cfg_mode               0=off, 1=sawtooth, 2=triangle, 3=square
//   cfg_max / cfg_min      requested amplitude limits
//   cfg_div                sample period minus 1, in clocks
//   cfg_err                one-cycle pulse: last accepted request was rejected
//   active_mode/max/min    configuration currently driven to the generators
//   step_h                 applied per-sample increment
//   sample_tick            one-cycle sample strobe
//   sample_idx             sample index within the period, 0..N_POINTS-1
//   period_start           high with the sample_tick where sample_idx becomes 0
//   dbg_state              controller state (IDLE=0, DIVIDE=1, PENDING=2, RUN=3)
//
// Handshake: a request transfers on any rising edge where cfg_valid and
// cfg_ready are both high. The requester holds cfg_* stable while cfg_valid is
// high. cfg_ready is a function of state only: it is high in IDLE and RUN and
// low in DIVIDE and PENDING, because there is a single staging slot.
// -----------------------------------------------------------------------------
module wave_sequencer_ctrl #(
  parameter int N_POINTS = 100,
  parameter int DATA_W   = 12,
  parameter int DIV_W    = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_mode,
  input  logic [DATA_W-1:0] cfg_max,
  input  logic [DATA_W-1:0] cfg_min,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [1:0]        active_mode,
  output logic [DATA_W-1:0] active_max,
  output logic [DATA_W-1:0] active_min,
  output logic [DATA_W-1:0] step_h,
  output logic              sample_tick,
  output logic [6:0]        sample_idx,
  output logic              period_start,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DIVIDE  = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;
  localparam logic [1:0] ST_RUN     = 2'd3;

  localparam logic [1:0] MODE_OFF = 2'd0;
  localparam logic [1:0] MODE_SAW = 2'd1;
  localparam logic [1:0] MODE_TRI = 2'd2;
  localparam logic [1:0] MODE_SQR = 2'd3;

  localparam int              CNT_W       = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER  = CNT_W'(DATA_W - 1);
  localparam logic [6:0]       LAST_IDX   = 7'(N_POINTS - 1);
  localparam logic [DATA_W-1:0] SAW_DIVISOR = DATA_W'(N_POINTS - 1);
  localparam logic [DATA_W-1:0] TRI_DIVISOR = DATA_W'(N_POINTS / 2 - 1);
  localparam logic [DATA_W-1:0] ONE_DIVISOR = DATA_W'(1);

  // Controller state
  logic [1:0]        state_q,    state_d;
  logic              cfg_err_q,  cfg_err_d;

  // Staging slot
  logic [1:0]        stg_mode_q, stg_mode_d;
  logic [DATA_W-1:0] stg_max_q,  stg_max_d;
  logic [DATA_W-1:0] stg_min_q,  stg_min_d;
  logic [DIV_W-1:0]  stg_div_q,  stg_div_d;
  logic [DATA_W-1:0] stg_step_q, stg_step_d;

  // Restoring divider: acc starts as the numerator and ends as the quotient
  logic [DATA_W-1:0] rem_q,      rem_d;
  logic [DATA_W-1:0] acc_q,      acc_d;
  logic [CNT_W-1:0]  iter_q,     iter_d;

  // Applied configuration
  logic [1:0]        act_mode_q, act_mode_d;
  logic [DATA_W-1:0] act_max_q,  act_max_d;
  logic [DATA_W-1:0] act_min_q,  act_min_d;
  logic [DATA_W-1:0] act_step_q, act_step_d;
  logic [DIV_W-1:0]  act_div_q,  act_div_d;

  // Sample sequencing
  logic [DIV_W-1:0]  cnt_q,      cnt_d;
  logic [6:0]        idx_q,      idx_d;
  logic              tick_q,     tick_d;
  logic              pstart_q,   pstart_d;
  logic              primed_q,   primed_d;

  // Combinational helpers
  logic              ready_w;
  logic              xfer;
  logic              req_bad;
  logic              running;
  logic              fire;
  logic              wrap;
  logic [DATA_W-1:0] divisor;
  logic [DATA_W:0]   rem_shift;
  logic [DATA_W-1:0] rem_sub;
  logic              quo_bit;
  logic [DATA_W-1:0] acc_next;

  assign ready_w = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign xfer    = cfg_valid && ready_w;
  assign req_bad = (cfg_mode != MODE_OFF) && (cfg_min > cfg_max);
  // The generators run whenever a non-off mode is applied, which also tells
  // whether a staged config came from IDLE (apply at once) or RUN (wait).
  assign running = (act_mode_q != MODE_OFF);
  assign fire    = running && (cnt_q == act_div_q);
  // primed_q makes the very first tick after a start from IDLE a period start.
  assign wrap    = fire && (primed_q || (idx_q == LAST_IDX));

  // One restoring-division step per clock.
  always_comb begin
    case (stg_mode_q)
      MODE_SAW: divisor = SAW_DIVISOR;
      MODE_TRI: divisor = TRI_DIVISOR;
      default:  divisor = ONE_DIVISOR;  // result unused for off/square
    endcase
    rem_shift = {rem_q, acc_q[DATA_W-1]};
    if (rem_shift >= {1'b0, divisor}) begin
      quo_bit = 1'b1;
      // The true difference is below divisor, so it fits in DATA_W bits.
      rem_sub = rem_shift[DATA_W-1:0] - divisor;
    end else begin
      quo_bit = 1'b0;
      rem_sub = rem_shift[DATA_W-1:0];
    end
    acc_next = {acc_q[DATA_W-2:0], quo_bit};
  end

  always_comb begin
    state_d    = state_q;
    cfg_err_d  = 1'b0;
    stg_mode_d = stg_mode_q;
    stg_max_d  = stg_max_q;
    stg_min_d  = stg_min_q;
    stg_div_d  = stg_div_q;
    stg_step_d = stg_step_q;
    rem_d      = rem_q;
    acc_d      = acc_q;
    iter_d     = iter_q;
    act_mode_d = act_mode_q;
    act_max_d  = act_max_q;
    act_min_d  = act_min_q;
    act_step_d = act_step_q;
    act_div_d  = act_div_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    tick_d     = 1'b0;
    pstart_d   = 1'b0;
    primed_d   = primed_q;

    // Sample strobe generation runs independently of the config FSM so that
    // ticks keep flowing while a new config is divided and staged.
    if (running) begin
      if (fire) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        if (wrap) begin
          idx_d    = '0;
          pstart_d = 1'b1;
          primed_d = 1'b0;
        end else begin
          idx_d = idx_q + 7'd1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (xfer) begin
          if (req_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            stg_mode_d = cfg_mode;
            stg_max_d  = cfg_max;
            stg_min_d  = cfg_min;
            stg_div_d  = cfg_div;
            acc_d      = cfg_max - cfg_min;
            rem_d      = '0;
            iter_d     = '0;
            state_d    = ST_DIVIDE;
          end
        end
      end

      ST_DIVIDE: begin
        rem_d  = rem_sub;
        acc_d  = acc_next;
        iter_d = iter_q + 1'b1;
        if (iter_q == LAST_ITER) begin
          state_d = ST_PENDING;
          case (stg_mode_q)
            MODE_OFF: stg_step_d = '0;
            MODE_SQR: stg_step_d = stg_max_q - stg_min_q;
            default:  stg_step_d = acc_next;
          endcase
        end
      end

      ST_PENDING: begin
        // From IDLE apply immediately; from RUN only on the wrap edge. A wrap
        // that coincided with the last divide cycle was seen in DIVIDE and is
        // therefore skipped here.
        if (!running || wrap) begin
          cnt_d    = '0;
          primed_d = 1'b0;
          if (stg_mode_q == MODE_OFF) begin
            act_mode_d = MODE_OFF;
            act_max_d  = '0;
            act_min_d  = '0;
            act_step_d = '0;
            act_div_d  = '0;
            idx_d      = '0;
            tick_d     = 1'b0;
            pstart_d   = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            act_mode_d = stg_mode_q;
            act_max_d  = stg_max_q;
            act_min_d  = stg_min_q;
            act_step_d = stg_step_q;
            act_div_d  = stg_div_q;
            state_d    = ST_RUN;
            if (!running) begin
              primed_d = 1'b1;
              idx_d    = '0;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cfg_err_q  <= 1'b0;
      stg_mode_q <= MODE_OFF;
      stg_max_q  <= '0;
      stg_min_q  <= '0;
      stg_div_q  <= '0;
      stg_step_q <= '0;
      rem_q      <= '0;
      acc_q      <= '0;
      iter_q     <= '0;
      act_mode_q <= MODE_OFF;
      act_max_q  <= '0;
      act_min_q  <= '0;
      act_step_q <= '0;
      act_div_q  <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      tick_q     <= 1'b0;
      pstart_q   <= 1'b0;
      primed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_err_q  <= cfg_err_d;
      stg_mode_q <= stg_mode_d;
      stg_max_q  <= stg_max_d;
      stg_min_q  <= stg_min_d;
      stg_div_q  <= stg_div_d;
      stg_step_q <= stg_step_d;
      rem_q      <= rem_d;
      acc_q      <= acc_d;
      iter_q     <= iter_d;
      act_mode_q <= act_mode_d;
      act_max_q  <= act_max_d;
      act_min_q  <= act_min_d;
      act_step_q <= act_step_d;
      act_div_q  <= act_div_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      tick_q     <= tick_d;
      pstart_q   <= pstart_d;
      primed_q   <= primed_d;
    end
  end

  assign cfg_ready    = ready_w;
  assign cfg_err      = cfg_err_q;
  assign active_mode  = act_mode_q;
  assign active_max   = act_max_q;
  assign active_min   = act_min_q;
  assign step_h       = act_step_q;
  assign sample_tick  = tick_q;
  assign sample_idx   = idx_q;
  assign period_start = pstart_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_wave_sequencer_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for wave_sequencer_ctrl.
// A vector table exercises single configurations applied from IDLE. Each
// vector covers the handshake, the error pulse, the apply latency, the step
// value and the first tick. Hand-written sequences then cover mid-run
// reconfiguration, boundary coincidence, turning the generator off, and an
// asynchronous reset while a config is pending.
// -----------------------------------------------------------------------------
module tb_wave_sequencer_ctrl;
  localparam int N_POINTS = 100;
  localparam int DATA_W   = 12;
  localparam int DIV_W    = 16;
  localparam int EXP_W    = 2 + 3 * DATA_W;
  localparam int N_VEC    = 16;

  // ---------------- clock / reset ----------------
  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic [1:0]        cfg_mode = '0;
  logic [DATA_W-1:0] cfg_max = '0;
  logic [DATA_W-1:0] cfg_min = '0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic              cfg_ready;
  logic              cfg_err;
  logic [1:0]        active_mode;
  logic [DATA_W-1:0] active_max;
  logic [DATA_W-1:0] active_min;
  logic [DATA_W-1:0] step_h;
  logic              sample_tick;
  logic [6:0]        sample_idx;
  logic              period_start;
  logic [1:0]        dbg_state;

  always #5 clock = ~clock;

  wave_sequencer_ctrl #(.N_POINTS(N_POINTS), .DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mode(cfg_mode), .cfg_max(cfg_max), .cfg_min(cfg_min), .cfg_div(cfg_div),
    .cfg_err(cfg_err),
    .active_mode(active_mode), .active_max(active_max), .active_min(active_min),
    .step_h(step_h),
    .sample_tick(sample_tick), .sample_idx(sample_idx), .period_start(period_start),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [EXP_W-1:0] exp_q[$];

  typedef struct {
    logic [1:0]        mode;
    logic [DATA_W-1:0] maxv;
    logic [DATA_W-1:0] minv;
    logic [DIV_W-1:0]  div;
    logic              exp_err;
    logic [DATA_W-1:0] exp_step;
  } vec_t;

  vec_t vecs[N_VEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [EXP_W-1:0] pack(input logic [1:0] m, input logic [DATA_W-1:0] mx,
                                            input logic [DATA_W-1:0] mn, input logic [DATA_W-1:0] st);
    return {m, mx, mn, st};
  endfunction

  task automatic sb_pop_compare(input string name);
    logic [EXP_W-1:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check(name, {active_mode, active_max, active_min, step_h}, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    cfg_valid = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic check_reset_state(input string p);
    check({p, "_cfg_ready"}, cfg_ready, 1);
    check({p, "_cfg_err"}, cfg_err, 0);
    check({p, "_active"}, {active_mode, active_max, active_min, step_h}, 0);
    check({p, "_tick"}, sample_tick, 0);
    check({p, "_idx"}, sample_idx, 0);
    check({p, "_pstart"}, period_start, 0);
    check({p, "_state"}, dbg_state, 0);
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_cfg(input logic [1:0] m, input logic [DATA_W-1:0] mx,
                          input logic [DATA_W-1:0] mn, input logic [DIV_W-1:0] d);
    int n;
    n = 0;
    while (!cfg_ready && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (!cfg_ready) check("send_ready_timeout", 0, 1);
    cfg_mode = m; cfg_max = mx; cfg_min = mn; cfg_div = d;
    cfg_valid = 1'b1;
    @(negedge clock);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_ready(output int lat, input int budget);
    lat = 0;
    while (!cfg_ready && lat < budget) begin
      lat++;
      @(negedge clock);
    end
    if (!cfg_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_tick(output int k, input int budget);
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!sample_tick && k < budget);
    if (!sample_tick) check("tick_timeout", 0, 1);
  endtask

  task automatic quiet_check(input string p, input int cycles);
    int bad;
    bad = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      if (sample_tick || sample_idx != 0 || active_mode != 0) bad++;
    end
    check({p, "_quiet"}, bad, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, k, bad, n, early, ticks, seen;
    logic [DATA_W-1:0] first_max;
    int unsigned a, b;

    vecs[0]  = '{2'd2, 12'd4000, 12'd0,    16'd3, 1'b0, 12'd81};
    vecs[1]  = '{2'd1, 12'd2000, 12'd1000, 16'd0, 1'b0, 12'd10};
    vecs[2]  = '{2'd3, 12'd4095, 12'd0,    16'd2, 1'b0, 12'd4095};
    vecs[3]  = '{2'd1, 12'd4095, 12'd0,    16'd1, 1'b0, 12'd41};
    vecs[4]  = '{2'd2, 12'd100,  12'd50,   16'd0, 1'b0, 12'd1};
    vecs[5]  = '{2'd2, 12'd48,   12'd0,    16'd1, 1'b0, 12'd0};
    vecs[6]  = '{2'd1, 12'd777,  12'd777,  16'd0, 1'b0, 12'd0};
    vecs[7]  = '{2'd0, 12'd10,   12'd5,    16'd0, 1'b0, 12'd0};
    vecs[8]  = '{2'd1, 12'd200,  12'd300,  16'd0, 1'b1, 12'd0};
    vecs[9]  = '{2'd2, 12'd0,    12'd1,    16'd3, 1'b1, 12'd0};
    vecs[10] = '{2'd0, 12'd5,    12'd10,   16'd0, 1'b0, 12'd0};
    vecs[11] = '{2'd3, 12'd1000, 12'd999,  16'd0, 1'b0, 12'd1};
    for (int i = 12; i < N_VEC; i++) begin
      a = $urandom_range(0, 4095);
      b = $urandom_range(0, 4095);
      vecs[i].mode = 2'($urandom_range(1, 3));
      vecs[i].maxv = DATA_W'((a > b) ? a : b);
      vecs[i].minv = DATA_W'((a > b) ? b : a);
      vecs[i].div  = DIV_W'($urandom_range(0, 3));
      vecs[i].exp_err = 1'b0;
      case (vecs[i].mode)
        2'd1:    vecs[i].exp_step = DATA_W'(int'(vecs[i].maxv - vecs[i].minv) / (N_POINTS - 1));
        2'd2:    vecs[i].exp_step = DATA_W'(int'(vecs[i].maxv - vecs[i].minv) / (N_POINTS / 2 - 1));
        default: vecs[i].exp_step = vecs[i].maxv - vecs[i].minv;
      endcase
    end

    // ---- table: each vector applied from IDLE ----
    for (int i = 0; i < N_VEC; i++) begin
      do_reset();
      check_reset_state($sformatf("v%0d_reset", i));
      send_cfg(vecs[i].mode, vecs[i].maxv, vecs[i].minv, vecs[i].div);
      if (vecs[i].exp_err) begin
        check($sformatf("v%0d_err_pulse", i), cfg_err, 1);
        check($sformatf("v%0d_err_ready", i), cfg_ready, 1);
        @(negedge clock);
        check($sformatf("v%0d_err_clear", i), cfg_err, 0);
        check($sformatf("v%0d_err_state", i), dbg_state, 0);
        check($sformatf("v%0d_err_active", i), {active_mode, step_h}, 0);
      end else begin
        check($sformatf("v%0d_no_err", i), cfg_err, 0);
        if (vecs[i].mode == 2'd0) exp_q.push_back(pack(2'd0, '0, '0, '0));
        else exp_q.push_back(pack(vecs[i].mode, vecs[i].maxv, vecs[i].minv, vecs[i].exp_step));
        wait_ready(lat, 100);
        check($sformatf("v%0d_apply_latency", i), lat, DATA_W + 1);
        sb_pop_compare($sformatf("v%0d_apply", i));
        if (vecs[i].mode != 2'd0) begin
          wait_tick(k, 100);
          check($sformatf("v%0d_first_tick_delay", i), k, vecs[i].div + 1);
          check($sformatf("v%0d_first_idx", i), sample_idx, 0);
          check($sformatf("v%0d_first_pstart", i), period_start, 1);
        end else begin
          check($sformatf("v%0d_off_state", i), dbg_state, 0);
          quiet_check($sformatf("v%0d_off", i), 20);
        end
      end
    end

    // ---- triangle run: tick cadence and full period ----
    do_reset();
    send_cfg(2'd2, 12'd4000, 12'd0, 16'd3);
    exp_q.push_back(pack(2'd2, 12'd4000, 12'd0, 12'd81));
    wait_ready(lat, 100);
    check("t1_apply_latency", lat, DATA_W + 1);
    sb_pop_compare("t1_apply");
    wait_tick(k, 50);
    check("t1_first_tick_delay", k, 4);
    check("t1_first_pstart", period_start, 1);
    bad = 0;
    for (int t = 1; t < N_POINTS; t++) begin
      wait_tick(k, 50);
      if (k != 4 || sample_idx != 7'(t) || period_start) bad++;
    end
    check("t1_tick_sequence_errors", bad, 0);
    wait_tick(k, 50);
    check("t1_wrap_spacing", k, 4);
    check("t1_wrap_idx", sample_idx, 0);
    check("t1_wrap_pstart", period_start, 1);

    // ---- sawtooth sent mid-period: held until the wrap ----
    repeat (30) wait_tick(k, 50);
    send_cfg(2'd1, 12'd2000, 12'd1000, 16'd0);
    exp_q.push_back(pack(2'd1, 12'd2000, 12'd1000, 12'd10));
    early = 0;
    n = 0;
    while (!(sample_tick && period_start) && n < 1000) begin
      if (active_mode != 2'd2 || step_h != 12'd81 || active_max != 12'd4000) early++;
      n++;
      @(negedge clock);
    end
    check("t2_held_until_wrap", early, 0);
    check("t2_wrap_reached", (n < 1000), 1);
    sb_pop_compare("t2_apply");
    check("t2_wrap_idx", sample_idx, 0);
    @(negedge clock);
    check("t2_tick_every_clock_a", {sample_tick, sample_idx}, {1'b1, 7'd1});
    @(negedge clock);
    check("t2_tick_every_clock_b", {sample_tick, sample_idx}, {1'b1, 7'd2});

    // ---- invalid request while running ----
    send_cfg(2'd1, 12'd200, 12'd300, 16'd0);
    check("t3_err_pulse", cfg_err, 1);
    check("t3_ready_kept", cfg_ready, 1);
    @(negedge clock);
    check("t3_err_clear", cfg_err, 0);
    check("t3_state_run", dbg_state, 3);
    check("t3_active_unchanged", {active_mode, active_max, active_min, step_h},
          pack(2'd1, 12'd2000, 12'd1000, 12'd10));

    // ---- divide completes on the same edge as a wrap ----
    n = 0;
    while (sample_idx != 7'd87 && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("t4_align_found", sample_idx, 87);
    cfg_mode = 2'd1; cfg_max = 12'd3000; cfg_min = 12'd1000; cfg_div = 16'd0;
    cfg_valid = 1'b1;
    @(negedge clock);
    cfg_valid = 1'b0;
    exp_q.push_back(pack(2'd1, 12'd3000, 12'd1000, 12'd20));
    lat = 0; seen = 0; first_max = '0;
    while (!cfg_ready && lat < 400) begin
      if (sample_tick && period_start && seen == 0) begin
        seen = 1;
        first_max = active_max;
      end
      lat++;
      @(negedge clock);
    end
    check("t4_coincident_wrap_seen", seen, 1);
    check("t4_coincident_wrap_old_max", first_max, 2000);
    check("t4_apply_latency", lat, N_POINTS + DATA_W);
    sb_pop_compare("t4_apply");
    check("t4_apply_pstart", period_start, 1);

    // ---- square from RUN ----
    send_cfg(2'd3, 12'd4095, 12'd0, 16'd1);
    exp_q.push_back(pack(2'd3, 12'd4095, 12'd0, 12'd4095));
    wait_ready(lat, 400);
    sb_pop_compare("t5_apply");
    check("t5_apply_tick", {sample_tick, period_start, sample_idx}, {1'b1, 1'b1, 7'd0});
    @(negedge clock);
    check("t5_gap", sample_tick, 0);
    @(negedge clock);
    check("t5_next_tick", {sample_tick, sample_idx}, {1'b1, 7'd1});

    // ---- off while running ----
    send_cfg(2'd0, 12'd0, 12'd0, 16'd0);
    exp_q.push_back(pack(2'd0, '0, '0, '0));
    ticks = 0; lat = 0;
    while (!cfg_ready && lat < 1000) begin
      if (sample_tick) ticks++;
      lat++;
      @(negedge clock);
    end
    check("t6_ticks_until_wrap", (ticks > 50), 1);
    sb_pop_compare("t6_apply");
    check("t6_apply_no_tick", {sample_tick, period_start, sample_idx}, 0);
    check("t6_state_idle", dbg_state, 0);
    quiet_check("t6_off", 40);

    // ---- asynchronous reset while a config is pending ----
    send_cfg(2'd2, 12'd1000, 12'd0, 16'd2);
    exp_q.push_back(pack(2'd2, 12'd1000, 12'd0, 12'd20));
    wait_ready(lat, 100);
    sb_pop_compare("t7_apply");
    n = 0;
    do begin
      wait_tick(k, 10);
      n++;
    end while (!period_start && n < 200);
    send_cfg(2'd1, 12'd1000, 12'd0, 16'd0);
    repeat (20) @(negedge clock);
    check("t7_pending", dbg_state, 2);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1 check_reset_state("t7_async");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("t7_ready_after", cfg_ready, 1);
    quiet_check("t7_after_reset", 40);

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
